// File: rtl/i2c_slave_buf.sv
// i2c_slave_buf: I2C target answering one 7-bit address, backed by a byte
// buffer that the bus writes/reads and the host can preload and inspect.
module i2c_slave_buf #(
    parameter logic [6:0] SLAVE_ADDR = 7'h22,
    parameter int         DEPTH      = 32,
    parameter int         FILT_LEN   = 3,
    parameter int         HOLD_CYC   = 4,
    localparam int        AW         = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          scl_o,
    output logic          sda_o,
    input  logic          host_we_i,
    input  logic [AW-1:0] host_addr_i,
    input  logic [7:0]    host_wdata_i,
    output logic [7:0]    host_rdata_o,
    output logic          wr_strb_o,
    output logic [AW-1:0] wr_idx_o,
    output logic [7:0]    wr_byte_o,
    output logic          busy_o,
    output logic          rw_o,
    output logic          done_o
);

    localparam int HW = $clog2(HOLD_CYC + 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        IGNORE
    } state_t;

    logic [1:0]          scl_sync, sda_sync;
    logic [FILT_LEN-1:0] scl_hist, sda_hist;
    logic                scl_f, sda_f, scl_q, sda_q;
    logic                scl_rise, scl_fall, start_det, stop_det;

    state_t        state, state_n;
    logic [3:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shreg, shreg_n;
    logic [AW-1:0] ptr, ptr_n, ptr_inc;
    logic          ack_drv, ack_drv_n;
    logic          busy_n, rw_n, done_n;
    logic          wr_strb_n;
    logic [AW-1:0] wr_idx_n;
    logic [7:0]    wr_byte_n;
    logic [7:0]    rx_byte;
    logic          mem_we, sched, want, rel;
    logic          sda_pend;
    logic [HW-1:0] hold_cnt;

    logic [7:0] mem [DEPTH];

    assign scl_o = 1'b1;

    // Synchronize, then only move a filtered level after a full run of equal samples
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_hist <= '1;
            sda_hist <= '1;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
            scl_hist <= (scl_hist << 1) | FILT_LEN'(scl_sync[1]);
            sda_hist <= (sda_hist << 1) | FILT_LEN'(sda_sync[1]);
            if (&scl_hist) begin
                scl_f <= 1'b1;
            end else if (~|scl_hist) begin
                scl_f <= 1'b0;
            end
            if (&sda_hist) begin
                sda_f <= 1'b1;
            end else if (~|sda_hist) begin
                sda_f <= 1'b0;
            end
            scl_q <= scl_f;
            sda_q <= sda_f;
        end
    end

    assign scl_rise  = scl_f & ~scl_q;
    assign scl_fall  = ~scl_f & scl_q;
    assign start_det = scl_f & scl_q & sda_q & ~sda_f;
    assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;
    assign rx_byte   = {shreg[6:0], sda_f};
    assign ptr_inc   = ptr + 1'b1;

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        ptr_n     = ptr;
        ack_drv_n = ack_drv;
        busy_n    = busy_o;
        rw_n      = rw_o;
        done_n    = 1'b0;
        wr_strb_n = 1'b0;
        wr_idx_n  = wr_idx_o;
        wr_byte_n = wr_byte_o;
        mem_we    = 1'b0;
        sched     = 1'b0;
        want      = 1'b1;
        rel       = 1'b0;
        unique case (state)
            IDLE: ;
            ADDR: begin
                if (scl_rise) begin
                    shreg_n   = rx_byte;
                    bit_cnt_n = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        bit_cnt_n = 4'd0;
                        if (rx_byte[7:1] == SLAVE_ADDR) begin
                            rw_n      = rx_byte[0];
                            busy_n    = 1'b1;
                            ack_drv_n = 1'b0;
                            state_n   = ADDR_ACK;
                        end else begin
                            state_n = IGNORE;
                        end
                    end
                end
            end
            ADDR_ACK, WR_ACK: begin
                // First falling edge pulls the ACK low, the next one ends it
                if (scl_fall) begin
                    sched     = 1'b1;
                    bit_cnt_n = 4'd0;
                    if (!ack_drv) begin
                        ack_drv_n = 1'b1;
                        want      = 1'b0;
                    end else if (state == ADDR_ACK && rw_o) begin
                        ack_drv_n = 1'b0;
                        shreg_n   = mem[ptr];
                        want      = mem[ptr][7];
                        state_n   = RD_DATA;
                    end else begin
                        ack_drv_n = 1'b0;
                        state_n   = WR_DATA;
                    end
                end
            end
            WR_DATA: begin
                if (scl_rise) begin
                    shreg_n   = rx_byte;
                    bit_cnt_n = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        bit_cnt_n = 4'd0;
                        mem_we    = 1'b1;
                        wr_strb_n = 1'b1;
                        wr_idx_n  = ptr;
                        wr_byte_n = rx_byte;
                        ptr_n     = ptr_inc;
                        ack_drv_n = 1'b0;
                        state_n   = WR_ACK;
                    end
                end
            end
            RD_DATA: begin
                if (scl_rise) begin
                    bit_cnt_n = bit_cnt + 4'd1;
                end else if (scl_fall) begin
                    sched = 1'b1;
                    unique case (1'b1)
                        (bit_cnt == 4'd0): want = shreg[7];
                        (bit_cnt == 4'd8): begin
                            want      = 1'b1;
                            bit_cnt_n = 4'd0;
                            state_n   = RD_ACK;
                        end
                        default: begin
                            want    = shreg[6];
                            shreg_n = {shreg[6:0], 1'b0};
                        end
                    endcase
                end
            end
            RD_ACK: begin
                if (scl_rise) begin
                    if (!sda_f) begin
                        ptr_n     = ptr_inc;
                        shreg_n   = mem[ptr_inc];
                        bit_cnt_n = 4'd0;
                        state_n   = RD_DATA;
                    end else begin
                        state_n = IGNORE;
                    end
                end
            end
            IGNORE: ;
            default: state_n = IDLE;
        endcase
        if (start_det) begin
            state_n   = ADDR;
            bit_cnt_n = 4'd0;
            ptr_n     = '0;
            busy_n    = 1'b0;
            ack_drv_n = 1'b0;
            sched     = 1'b0;
            rel       = 1'b1;
        end else if (stop_det) begin
            state_n   = IDLE;
            busy_n    = 1'b0;
            done_n    = busy_o;
            ack_drv_n = 1'b0;
            sched     = 1'b0;
            rel       = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= IDLE;
            bit_cnt      <= 4'd0;
            shreg        <= 8'd0;
            ptr          <= '0;
            ack_drv      <= 1'b0;
            busy_o       <= 1'b0;
            rw_o         <= 1'b0;
            done_o       <= 1'b0;
            wr_strb_o    <= 1'b0;
            wr_idx_o     <= '0;
            wr_byte_o    <= 8'd0;
            host_rdata_o <= 8'd0;
        end else begin
            state        <= state_n;
            bit_cnt      <= bit_cnt_n;
            shreg        <= shreg_n;
            ptr          <= ptr_n;
            ack_drv      <= ack_drv_n;
            busy_o       <= busy_n;
            rw_o         <= rw_n;
            done_o       <= done_n;
            wr_strb_o    <= wr_strb_n;
            wr_idx_o     <= wr_idx_n;
            wr_byte_o    <= wr_byte_n;
            host_rdata_o <= mem[host_addr_i];
        end
    end

    // New SDA level waits out the hold time after SCL falls
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sda_o    <= 1'b1;
            sda_pend <= 1'b1;
            hold_cnt <= '0;
        end else if (rel) begin
            sda_o    <= 1'b1;
            hold_cnt <= '0;
        end else if (sched) begin
            sda_pend <= want;
            hold_cnt <= HW'(HOLD_CYC);
        end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
            if (hold_cnt == HW'(1)) begin
                sda_o <= sda_pend;
            end
        end
    end

    // Bus write is ordered last so it wins a same-index collision
    always_ff @(posedge clk_i) begin
        if (host_we_i) begin
            mem[host_addr_i] <= host_wdata_i;
        end
        if (mem_we) begin
            mem[ptr] <= rx_byte;
        end
    end

endmodule

// File: tb/tb_i2c_slave_buf.sv
// Bench for i2c_slave_buf: bit-banged master, host port accesses and a
// scoreboard of expected buffer writes and read-back bytes.
`timescale 1ns/1ps
module tb_i2c_slave_buf;

    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int QT    = 100;

    logic          clk_i = 1'b0;
    logic          rst_n_i = 1'b0;
    logic          scl_m = 1'b1;
    logic          sda_m = 1'b1;
    logic          scl_i, sda_i, scl_o, sda_o;
    logic          host_we_i = 1'b0;
    logic [AW-1:0] host_addr_i = '0;
    logic [7:0]    host_wdata_i = 8'd0;
    logic [7:0]    host_rdata_o;
    logic          wr_strb_o;
    logic [AW-1:0] wr_idx_o;
    logic [7:0]    wr_byte_o;
    logic          busy_o, rw_o, done_o;

    assign scl_i = scl_m & scl_o;
    assign sda_i = sda_m & sda_o;

    i2c_slave_buf dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .scl_i        (scl_i),
        .sda_i        (sda_i),
        .scl_o        (scl_o),
        .sda_o        (sda_o),
        .host_we_i    (host_we_i),
        .host_addr_i  (host_addr_i),
        .host_wdata_i (host_wdata_i),
        .host_rdata_o (host_rdata_o),
        .wr_strb_o    (wr_strb_o),
        .wr_idx_o     (wr_idx_o),
        .wr_byte_o    (wr_byte_o),
        .busy_o       (busy_o),
        .rw_o         (rw_o),
        .done_o       (done_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int strb_cnt = 0;
    int done_cnt = 0;
    int glitches = 0;
    logic prev_sda = 1'b1;
    logic prev_rst = 1'b0;
    logic [15:0] wr_q [$];
    logic [7:0]  rd_q [$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk_i) begin
        logic [15:0] e;
        if (wr_strb_o) begin
            strb_cnt++;
            if (wr_q.size() == 0) begin
                chk("wr_unexpected", 32'(wr_idx_o), 32'hffff);
            end else begin
                e = wr_q.pop_front();
                chk("wr_idx", 32'(wr_idx_o), 32'(e[15:8]));
                chk("wr_byte", 32'(wr_byte_o), 32'(e[7:0]));
            end
        end
        if (done_o) done_cnt++;
        if (rst_n_i && prev_rst && sda_o !== prev_sda && scl_i) glitches++;
        prev_sda = sda_o;
        prev_rst = rst_n_i;
    end

    task automatic i2c_start();
        sda_m = 1'b1; #(QT);
        scl_m = 1'b1; #(QT);
        sda_m = 1'b0; #(QT);
        scl_m = 1'b0; #(QT);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #(QT);
        scl_m = 1'b1; #(QT);
        sda_m = 1'b1; #(2 * QT);
    endtask

    task automatic bit_xfer(input logic b, output logic r);
        sda_m = b;    #(QT);
        scl_m = 1'b1; #(QT);
        r = sda_i;    #(QT);
        scl_m = 1'b0; #(QT);
    endtask

    task automatic wr_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], r);
        bit_xfer(1'b1, ack);
    endtask

    task automatic rd_byte(input logic nack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, r);
            d[i] = r;
        end
        bit_xfer(nack, r);
    endtask

    task automatic host_wr(input int a, input logic [7:0] v);
        @(negedge clk_i);
        host_we_i = 1'b1;
        host_addr_i = AW'(a);
        host_wdata_i = v;
        @(negedge clk_i);
        host_we_i = 1'b0;
    endtask

    task automatic host_rd(input int a, output logic [7:0] v);
        @(negedge clk_i);
        host_addr_i = AW'(a);
        @(negedge clk_i);
        v = host_rdata_o;
    endtask

    initial begin
        #(5ms);
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic ack;
        logic [7:0] d, e;
        logic [7:0] a44;
        a44 = 8'h44;

        #20;
        chk("rst_sda", 32'(sda_o), 32'd1);
        chk("rst_scl", 32'(scl_o), 32'd1);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_rw", 32'(rw_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_strb", 32'(wr_strb_o), 32'd0);
        chk("rst_rdata", 32'(host_rdata_o), 32'd0);
        chk("rst_idx", 32'(wr_idx_o), 32'd0);
        chk("rst_byte", 32'(wr_byte_o), 32'd0);
        #32 rst_n_i = 1'b1;
        #(2 * QT);

        // 32-byte write
        i2c_start();
        wr_byte(8'h44, ack);
        chk("t1_addr_ack", 32'(ack), 32'd0);
        chk("t1_busy", 32'(busy_o), 32'd1);
        chk("t1_rw", 32'(rw_o), 32'd0);
        for (int i = 0; i < 32; i++) begin
            wr_q.push_back({8'(i), 8'(i)});
            wr_byte(8'(i), ack);
            chk("t1_data_ack", 32'(ack), 32'd0);
        end
        i2c_stop();
        chk("t1_done", 32'(done_cnt), 32'd1);
        chk("t1_strb", 32'(strb_cnt), 32'd32);
        chk("t1_busy_end", 32'(busy_o), 32'd0);
        for (int i = 0; i < 32; i++) begin
            host_rd(i, d);
            chk("t1_host_rd", 32'(d), 32'(i));
        end

        // 32-byte read of a host preload
        for (int i = 0; i < 32; i++) host_wr(i, 8'(100 + i));
        i2c_start();
        wr_byte(8'h45, ack);
        chk("t2_addr_ack", 32'(ack), 32'd0);
        chk("t2_rw", 32'(rw_o), 32'd1);
        for (int i = 0; i < 32; i++) begin
            rd_q.push_back(8'(100 + i));
            rd_byte(i == 31, d);
            e = rd_q.pop_front();
            chk("t2_rd", 32'(d), 32'(e));
        end
        chk("t2_nack_rel", 32'(sda_o), 32'd1);
        #(QT);
        chk("t2_rel_hold", 32'(sda_o), 32'd1);
        i2c_stop();
        chk("t2_done", 32'(done_cnt), 32'd2);
        chk("t2_strb", 32'(strb_cnt), 32'd32);

        // Foreign address
        i2c_start();
        wr_byte(8'h46, ack);
        chk("t3_nack", 32'(ack), 32'd1);
        chk("t3_busy", 32'(busy_o), 32'd0);
        i2c_stop();
        chk("t3_done", 32'(done_cnt), 32'd2);
        chk("t3_strb", 32'(strb_cnt), 32'd32);

        // 33-byte write wraps the pointer
        for (int i = 0; i < 32; i++) host_wr(i, 8'(200 + i));
        i2c_start();
        wr_byte(8'h44, ack);
        chk("t4_addr_ack", 32'(ack), 32'd0);
        for (int i = 0; i < 33; i++) begin
            wr_q.push_back({8'(i % DEPTH), 8'(i)});
            wr_byte(8'(i), ack);
            chk("t4_data_ack", 32'(ack), 32'd0);
        end
        i2c_stop();
        chk("t4_done", 32'(done_cnt), 32'd3);
        chk("t4_strb", 32'(strb_cnt), 32'd65);
        for (int i = 0; i < 32; i++) begin
            host_rd(i, d);
            chk("t4_host_rd", 32'(d), (i == 0) ? 32'd32 : 32'(i));
        end

        // Write, repeated START, read back
        i2c_start();
        wr_byte(8'h44, ack);
        chk("t5_addr_ack", 32'(ack), 32'd0);
        wr_q.push_back({8'd0, 8'hA5});
        wr_byte(8'hA5, ack);
        chk("t5_data_ack", 32'(ack), 32'd0);
        i2c_start();
        wr_byte(8'h45, ack);
        chk("t5_sr_ack", 32'(ack), 32'd0);
        chk("t5_rw", 32'(rw_o), 32'd1);
        chk("t5_busy", 32'(busy_o), 32'd1);
        rd_q.push_back(8'hA5);
        rd_byte(1'b1, d);
        e = rd_q.pop_front();
        chk("t5_rd", 32'(d), 32'(e));
        i2c_stop();
        chk("t5_done", 32'(done_cnt), 32'd4);

        // Reset while the address ACK is held low
        i2c_start();
        for (int i = 7; i >= 0; i--) bit_xfer(a44[i], ack);
        sda_m = 1'b1; #(QT);
        scl_m = 1'b1; #(QT);
        chk("t6_ack_hold", 32'(sda_o), 32'd0);
        chk("t6_busy_pre", 32'(busy_o), 32'd1);
        rst_n_i = 1'b0;
        #1;
        chk("t6_rst_sda", 32'(sda_o), 32'd1);
        chk("t6_rst_busy", 32'(busy_o), 32'd0);
        #(QT);
        scl_m = 1'b0; #(QT);
        rst_n_i = 1'b1;
        #(QT);
        i2c_start();
        wr_byte(8'h44, ack);
        chk("t6_addr_ack", 32'(ack), 32'd0);
        wr_q.push_back({8'd0, 8'h5A});
        wr_byte(8'h5A, ack);
        chk("t6_data_ack", 32'(ack), 32'd0);
        i2c_stop();
        chk("t6_done", 32'(done_cnt), 32'd5);
        chk("t6_strb", 32'(strb_cnt), 32'd67);

        chk("sda_chg_scl_hi", 32'(glitches), 32'd0);
        chk("wr_q_left", 32'(wr_q.size()), 32'd0);
        chk("rd_q_left", 32'(rd_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_slave_buf.md
Name: i2c_slave_buf

Overview:
- Synthesizable I2C target (slave) responder: the far end of the bus from the iicmb controller.
- Answers one 7-bit address. Stores bytes the master writes into an internal byte buffer and returns buffer contents on master reads.
- The host side can preload and inspect the buffer through a simple port.
- Used as a real target on an I2C bus in place of the behavioural slave model, and as a stand-alone reusable block.

Parameters:
- SLAVE_ADDR, 7'h22, 7-bit bus address this block answers.
- DEPTH, 32, buffer size in bytes; power of two, 2..256.
- FILT_LEN, 3, consecutive equal samples required before a filtered SCL/SDA level changes.
- HOLD_CYC, 4, clk_i cycles after a filtered SCL falling edge before sda_o may change.

Ports:
- clk_i  in  1  system clock; all logic is in this domain.
- rst_n_i  in  1  reset, asynchronous, active-low.
- scl_i  in  1  I2C clock, bus level.
- sda_i  in  1  I2C data, bus level.
- scl_o  out  1  open-drain SCL drive (0 = pull low, 1 = release); constant 1, no clock stretching.
- sda_o  out  1  open-drain SDA drive (0 = pull low, 1 = release).
- host_we_i  in  1  host buffer write strobe.
- host_addr_i  in  $clog2(DEPTH)  host buffer index.
- host_wdata_i  in  8  host write data.
- host_rdata_o  out  8  buffer[host_addr_i], registered, 1-cycle latency.
- wr_strb_o  out  1  1-cycle pulse per accepted I2C write byte.
- wr_idx_o  out  $clog2(DEPTH)  buffer index of that byte.
- wr_byte_o  out  8  value of that byte.
- busy_o  out  1  high from address match until STOP or START.
- rw_o  out  1  R/W bit of the current addressed transfer (1 = read).
- done_o  out  1  1-cycle pulse on STOP that ends an addressed transfer.

Behaviour:
- Reset (async, rst_n_i=0):
  - sda_o=1, scl_o=1.
  - wr_strb_o, done_o, busy_o, rw_o, host_rdata_o, wr_idx_o, wr_byte_o all 0.
  - State IDLE, pointer 0.
  - Buffer contents are not reset.
  - Asserting reset mid-transfer releases SDA in the same cycle, without waiting for a clock edge.
- Input conditioning:
  - 2-FF synchronizer on scl_i and sda_i, then a FILT_LEN-sample filter.
  - Edges are derived from the filtered levels only.
- START: filtered SDA 1->0 while filtered SCL=1. STOP: filtered SDA 0->1 while filtered SCL=1.
- START or STOP is honoured in every state; it overrides the current state the same cycle and releases SDA.
  - START (including repeated START): go to ADDR, clear bit counter, pointer=0.
  - STOP: go to IDLE, clear busy_o. If busy_o was 1, pulse done_o.
- Data is sampled on filtered SCL rising edges, MSB first.
- sda_o changes only HOLD_CYC cycles after a filtered SCL falling edge.
- State machine:
  - IDLE: wait for START.
  - ADDR: shift 8 bits.
    - If bits[7:1]==SLAVE_ADDR: latch rw_o=bit0, set busy_o, go to ADDR_ACK.
    - Otherwise go to IGNORE; SDA stays released, which gives a NACK.
  - ADDR_ACK: drive 0 for the 9th clock, release after the 9th falling edge.
    - rw_o=0: go to WR_DATA.
    - rw_o=1: go to RD_DATA, loading buffer[pointer] into the shift register.
  - WR_DATA: shift 8 bits. On the 8th rising edge:
    - buffer[pointer] <= byte;
    - pulse wr_strb_o with wr_idx_o=pointer, wr_byte_o=byte;
    - pointer <= pointer+1 mod DEPTH (wraps, no overflow error);
    - go to WR_ACK.
  - WR_ACK: drive 0 for the 9th clock, then return to WR_DATA.
  - RD_DATA: drive the 8 bits MSB first; the first bit is driven HOLD_CYC after the falling edge that ends the ACK clock. Release SDA after the 8th falling edge, then go to RD_ACK.
  - RD_ACK: sample SDA on the 9th rising edge.
    - 0 (ACK): pointer+1 mod DEPTH, load the next byte, go to RD_DATA.
    - 1 (NACK): go to IGNORE.
  - IGNORE: SDA released; wait for START or STOP.
- Simultaneous host_we_i and an I2C buffer write to the same index in one cycle: the I2C write wins.
- host_rdata_o reflects the post-write contents on the following cycle.
- The block never drives SDA low while filtered SCL is high, except when holding an ACK or data bit across that high phase.

Test Plan:
- Write 0x22 (byte 0x44) + 32 bytes 0..31 + STOP:
  - ACK on all 33 bytes.
  - 32 wr_strb_o pulses, idx 0..31 with byte=idx.
  - host reads return i at index i.
  - one done_o pulse.
- Host preloads 100..131; master reads 32 bytes from 0x22 (0x45), ACK x31, NACK last, STOP:
  - SDA carries 100..131.
  - sda_o=1 from the NACK until STOP.
  - no wr_strb_o.
- Address 0x23 write:
  - SDA high on the 9th clock (NACK), busy_o stays 0.
  - no strobes, no done_o at STOP.
- Write 33 bytes 0..32: the 33rd byte lands at idx 0, so buffer[0]=32 and buffer[1..31] are unchanged.
- Write 0xA5, repeated START, read 1 byte with NACK: read returns 0xA5 (pointer reset to 0), rw_o=1 after Sr.
- Assert rst_n_i while the slave holds the ACK low: sda_o=1 immediately, busy_o=0, next START is handled normally.
